rr_arb8_ctrl: RTL and testbench

RR_ARB8_CTRL -- requirements
Module: rr_arb8_ctrl

---
 rtl/rr_arb8_pkg.sv | 14 +
 rtl/decoder3to8.sv | 15 +
 rtl/rr_arb8_ctrl.sv | 114 +++++++++++
 tb/tb_rr_arb8_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb8_pkg.sv
// Shared constants and FSM encoding for the 8-way round-robin arbiter controller.
package rr_arb8_pkg;

    localparam int N_REQ  = 8;
    localparam int IDX_W  = 3;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs are zero while en is low.
module decoder3to8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 level-sensitive requesters. A grant is held until
// the owner pulses done, withdraws its request, or MAX_HOLD cycles elapse.
module rr_arb8_ctrl
    import rr_arb8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,               // legal range 1..255
    parameter int          N_REQ    = rr_arb8_pkg::N_REQ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic                 done,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_en,
    output logic [N_REQ-1:0]     gnt,
    output logic                 timeout,
    output logic [1:0]           dbg_state
);

    // Handshake: req[i] is a level held while requester i wants the bus; it is
    // sampled only in IDLE. done is a one-cycle pulse from the current owner and
    // is honoured only in GRANT. Withdrawing req during GRANT also releases.

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e              state_q;
    logic                gnt_en_q;
    logic [IDX_W-1:0]    gnt_idx_q;
    logic [IDX_W-1:0]    last_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                timeout_q;

    logic [IDX_W-1:0]    pick_d;
    logic                rel_d;

    // First set request strictly after last, wrapping; 3-bit add wraps mod 8.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] last
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + IDX_W'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign pick_d = rr_pick(req, last_q);
    assign rel_d  = done || !req[gnt_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_en_q   <= 1'b0;
            gnt_idx_q  <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_idx_q  <= pick_d;
                        last_q     <= pick_d;
                        gnt_en_q   <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    // Timeout is registered, so its pulse lands in the GAP cycle.
                    if (rel_d) begin
                        gnt_en_q <= 1'b0;
                        state_q  <= GAP;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        gnt_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= GAP;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    gnt_en_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_en    = gnt_en_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

    decoder3to8 u_gnt_dec (
        .in  (gnt_idx_q),
        .en  (gnt_en_q),
        .out (gnt)
    );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Self-checking bench for rr_arb8_ctrl: directed scenarios plus a random req/done
// stream checked every cycle against a behavioural round-robin model.
module tb_rr_arb8_ctrl;

    localparam int MAX_HOLD = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'h00;
    logic       done  = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic [7:0] gnt;
    logic       timeout;
    logic [1:0] dbg_state;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rr_arb8_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_en    (gnt_en),
        .gnt       (gnt),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an owner (if any), cycles it has held, cool-down count.
    bit m_active = 1'b0;
    int m_held   = 0;
    int m_cool   = 0;
    int m_last   = 7;
    int m_idx    = 0;
    bit m_to     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_held   = 0;
            m_cool   = 0;
            m_last   = 7;
            m_idx    = 0;
            m_to     = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_active) begin
                m_held++;
                if (done || !req[m_idx]) begin
                    m_active = 1'b0;
                    m_cool   = 1;
                end else if (m_held == MAX_HOLD) begin
                    m_to     = 1'b1;
                    m_active = 1'b0;
                    m_cool   = 1;
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (req != 8'h00) begin
                for (int k = 1; k <= 8; k++) begin
                    if (req[(m_last + k) % 8]) begin
                        m_idx = (m_last + k) % 8;
                        break;
                    end
                end
                m_last   = m_idx;
                m_active = 1'b1;
                m_held   = 0;
            end
        end
    end

    // Per-cycle comparison plus structural and fairness properties.
    int         waitc[8];
    bit         prev_en = 1'b0;
    logic [7:0] exp_gnt;

    always begin
        @(posedge clk);
        #1;
        exp_gnt = m_active ? 8'(1 << m_idx) : 8'h00;
        check("gnt_en", gnt_en, m_active);
        check("gnt_idx", gnt_idx, m_idx);
        check("timeout", timeout, m_to);
        check("gnt", gnt, exp_gnt);
        check("gnt_decode", gnt, gnt_en ? 8'(1 << gnt_idx) : 8'h00);
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) waitc[i] = 0;
        end else begin
            if (gnt_en && !prev_en) begin
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(gnt_idx)) begin
                        waitc[i] = 0;
                    end else if (req[i]) begin
                        waitc[i]++;
                        check("wait_bound", (waitc[i] <= 7), 1);
                    end
                end
            end
            for (int i = 0; i < 8; i++) if (!req[i]) waitc[i] = 0;
        end
        prev_en = gnt_en;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt_en", gnt_en, 0);
        check("rst_gnt", gnt, 8'h00);
        check("rst_gnt_idx", gnt_idx, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int         ng;
        int         gap;
        int         hc;
        bit         pe;
        logic [2:0] got[9];
        int         phase;
        logic [7:0] flip;

        // Single requester, release by done.
        do_reset();
        req = 8'h01;
        @(negedge clk);
        check("t029_gnt", gnt, 8'h01);
        check("t029_idx", gnt_idx, 0);
        check("t029_model_idx", m_idx, 0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        check("t029_hold", gnt, 8'h01);
        @(negedge clk);
        done = 1'b0;
        check("t029_release", gnt, 8'h00);
        check("t029_idx_kept", gnt_idx, 0);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // All requesting, done every grant cycle: rotation with wrap.
        do_reset();
        req = 8'hFF;
        ng  = 0;
        gap = 0;
        pe  = 1'b0;
        for (int c = 0; c < 200 && ng < 9; c++) begin
            @(negedge clk);
            if (gnt_en && !pe) begin
                got[ng] = gnt_idx;
                if (ng > 0) check("t030_gap", gap, 2);
                ng++;
                gap = 0;
            end else if (!gnt_en) begin
                gap++;
            end
            pe   = gnt_en;
            done = gnt_en;
        end
        check("t030_grants", ng, 9);
        for (int i = 0; i < 9; i++) begin
            if (i < ng) check("t030_order", got[i], i % 8);
        end
        @(negedge clk);
        done = 1'b0;
        req  = 8'h00;
        repeat (3) @(negedge clk);

        // Single requester that never releases: forced release, then re-grant.
        do_reset();
        req = 8'h10;
        @(negedge clk);
        hc = 0;
        while (gnt == 8'h10 && hc < 300) begin
            hc++;
            @(negedge clk);
        end
        check("t031_hold_len", hc, 16);
        check("t031_timeout", timeout, 1);
        check("t031_gnt_off", gnt, 8'h00);
        @(negedge clk);
        check("t031_timeout_pulse", timeout, 0);
        check("t031_idle", gnt, 8'h00);
        @(negedge clk);
        check("t031_regrant", gnt, 8'h10);
        check("t031_regrant_idx", gnt_idx, 4);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Owner withdraws mid-grant; next grant rotates past it.
        do_reset();
        req = 8'h84;
        @(negedge clk);
        check("t032_first", gnt_idx, 2);
        check("t032_first_gnt", gnt, 8'h04);
        @(negedge clk);
        req = 8'h80;
        @(negedge clk);
        check("t032_withdraw", gnt_en, 0);
        @(negedge clk);
        check("t032_gap", gnt, 8'h00);
        @(negedge clk);
        check("t032_next", gnt, 8'h80);
        check("t032_next_idx", gnt_idx, 7);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Asynchronous reset during a grant.
        do_reset();
        req = 8'h20;
        @(negedge clk);
        check("t033_grant", gnt_idx, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t033_async_gnt", gnt, 8'h00);
        check("t033_async_en", gnt_en, 0);
        check("t033_async_idx", gnt_idx, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t033_regrant", gnt, 8'h20);
        check("t033_regrant_idx", gnt_idx, 5);
        req = 8'h00;
        repeat (3) @(negedge clk);

        // Random req/done stream; alternating phases favour done or timeouts.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            phase = (c / 400) % 2;
            flip  = 8'h00;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 9) == 0);
            req  = req ^ flip;
            done = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
        end
        req  = 8'h00;
        done = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
